// File: rtl/divisor_restador_4bits_pkg.sv
// Shared definitions for the sequential restoring divider.
//   - estado_t : FSM state encoding (REPOSO, CALCULO, FIN)
//   - N_DEF    : default operand width
//   - cnt_w()  : iteration counter width for a given operand width
package divisor_restador_4bits_pkg;

   localparam int N_DEF = 4;

   typedef enum logic [1:0] {
      REPOSO  = 2'd0,
      CALCULO = 2'd1,
      FIN     = 2'd2
   } estado_t;

   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

   localparam int CNT_W_DEF = cnt_w(N_DEF);

endpackage

// File: rtl/restador_completo.sv
// One-bit full subtractor cell: diferencia = a - b - borrow_in.
// Ports:
//   a, b, borrow_in : operand bits and incoming borrow
//   diferencia      : difference bit
//   borrow_out      : borrow to the next more significant cell
module restador_completo (
   input  logic a,
   input  logic b,
   input  logic borrow_in,
   output logic diferencia,
   output logic borrow_out
);

   assign diferencia = a ^ b ^ borrow_in;
   assign borrow_out = (~a & b) | (~(a ^ b) & borrow_in);

endmodule

// File: rtl/restador_nbits.sv
// W-bit ripple-borrow subtractor built from a chain of restador_completo
// cells: diferencia = a - b, borrow_out = 1 when b > a (unsigned).
// Ports:
//   a, b       : W-bit unsigned operands
//   diferencia : W-bit difference (modulo 2^W)
//   borrow_out : borrow out of the most significant cell
module restador_nbits #(
   parameter int W = 5
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] diferencia,
   output logic         borrow_out
);

   logic [W:0] borrow;

   assign borrow[0] = 1'b0;

   for (genvar i = 0; i < W; i++) begin : g_celda
      restador_completo u_celda (
         .a          (a[i]),
         .b          (b[i]),
         .borrow_in  (borrow[i]),
         .diferencia (diferencia[i]),
         .borrow_out (borrow[i+1])
      );
   end

   assign borrow_out = borrow[W];

endmodule

// File: rtl/divisor_restador_4bits.sv
// Sequential restoring divider, one quotient bit per clock, with a
// start/done handshake.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   REPOSO  | idle, waiting for inicio; operands latched on acceptance
//   CALCULO | iterating, one shift/subtract/restore step per edge
//   FIN     | result valid on Cociente/Residuo/div_cero, listo pulse
//
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   inicio               : start request, accepted in REPOSO
//   Dividendo, Divisor   : unsigned operands, latched on acceptance
//   Cociente, Residuo    : registered quotient and remainder
//   ocupado              : high while iterating
//   listo                : one-cycle completion pulse
//   div_cero             : last operation divided by zero
module divisor_restador_4bits
   import divisor_restador_4bits_pkg::*;
#(
   parameter int N = N_DEF
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inicio,
   input  logic [N-1:0] Dividendo,
   input  logic [N-1:0] Divisor,
   output logic [N-1:0] Cociente,
   output logic [N-1:0] Residuo,
   output logic         ocupado,
   output logic         listo,
   output logic         div_cero
);

   localparam int CW = cnt_w(N);

   estado_t       estado, estado_sig;
   logic [N-1:0]  q, d;
   logic [N:0]    r;
   logic [CW-1:0] cnt;

   logic [N:0]    r_desp, diff, r_sig;
   logic [N-1:0]  q_sig;
   logic          borrow;

   // After every restore R < D, so R's MSB is zero and drops out of the shift.
   assign r_desp = (r << 1) | {{N{1'b0}}, q[N-1]};

   restador_nbits #(.W(N + 1)) u_restador (
      .a          (r_desp),
      .b          ({1'b0, d}),
      .diferencia (diff),
      .borrow_out (borrow)
   );

   assign q_sig = {q[N-2:0], ~borrow};
   assign r_sig = borrow ? r_desp : diff;

   always_ff @(posedge clk) begin
      if (reset) estado <= REPOSO;
      else       estado <= estado_sig;
   end

   always_comb begin
      estado_sig = estado;
      case (estado)
         REPOSO:  if (inicio) estado_sig = (Divisor == '0) ? FIN : CALCULO;
         CALCULO: if (cnt == '0) estado_sig = FIN;
         FIN:     estado_sig = REPOSO;
         default: estado_sig = REPOSO;
      endcase
   end

   always_comb begin
      ocupado = (estado == CALCULO);
      listo   = (estado == FIN);
   end

   // Iteration counter runs down from N-1; the step taken at zero is the last.
   always_ff @(posedge clk) begin
      if (reset) begin
         q        <= '0;
         d        <= '0;
         r        <= '0;
         cnt      <= '0;
         Cociente <= '0;
         Residuo  <= '0;
         div_cero <= 1'b0;
      end else begin
         case (estado)
            REPOSO: begin
               if (inicio) begin
                  q   <= Dividendo;
                  d   <= Divisor;
                  r   <= '0;
                  cnt <= CW'(N - 1);
                  if (Divisor == '0) begin
                     Cociente <= '1;
                     Residuo  <= Dividendo;
                     div_cero <= 1'b1;
                  end
               end
            end
            CALCULO: begin
               q <= q_sig;
               r <= r_sig;
               if (cnt == '0) begin
                  Cociente <= q_sig;
                  Residuo  <= r_sig[N-1:0];
                  div_cero <= 1'b0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_divisor_restador_4bits.sv
module tb_divisor_restador_4bits;
   import divisor_restador_4bits_pkg::*;

   localparam int N   = 4;
   localparam int PER = 10;

   logic         clk;
   logic         reset;
   logic         inicio;
   logic [N-1:0] Dividendo, Divisor;
   logic [N-1:0] Cociente, Residuo;
   logic         ocupado, listo, div_cero;

   divisor_restador_4bits #(.N(N)) dut (
      .clk       (clk),
      .reset     (reset),
      .inicio    (inicio),
      .Dividendo (Dividendo),
      .Divisor   (Divisor),
      .Cociente  (Cociente),
      .Residuo   (Residuo),
      .ocupado   (ocupado),
      .listo     (listo),
      .div_cero  (div_cero)
   );

   initial clk = 1'b0;
   always #(PER/2) clk = ~clk;

   typedef struct {
      logic [N-1:0] q;
      logic [N-1:0] r;
      logic         dz;
      int           t_listo;
      int           gap;
      int           busy;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   typedef struct {
      logic [N-1:0] a, b, q, r;
      logic         dz;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
      end
   endtask

   // t is the time of the accepting rising edge
   task automatic push_exp(input logic [N-1:0] q, input logic [N-1:0] r,
                           input logic dz, input int t, input int gap);
      exp_t e;
      e.q       = q;
      e.r       = r;
      e.dz      = dz;
      e.busy    = dz ? 0 : N;
      e.t_listo = dz ? t + PER/2 : t + N*PER + PER/2;
      e.gap     = gap;
      exp_q.push_back(e);
   endtask

   task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] q, input logic [N-1:0] r, input logic dz);
      @(negedge clk);
      Dividendo = a;
      Divisor   = b;
      inicio    = 1'b1;
      @(posedge clk);
      push_exp(q, r, dz, int'($time), 0);
      @(negedge clk);
      inicio    = 1'b0;
      Dividendo = ~a;
      Divisor   = ~b;
      repeat (dz ? 1 : N + 1) @(negedge clk);
   endtask

   // Monitor: pops one expectation per listo pulse
   initial begin
      int   run;
      int   last_listo;
      exp_t e;
      run        = 0;
      last_listo = 0;
      forever begin
         @(negedge clk);
         if (listo) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_listo: got listo=1, expected no pulse (t=%0t)", $time);
            end else begin
               e = exp_q.pop_front();
               chk("cociente", 32'(Cociente), 32'(e.q));
               chk("residuo", 32'(Residuo), 32'(e.r));
               chk("div_cero", 32'(div_cero), 32'(e.dz));
               chk("listo_time", 32'($time), 32'(e.t_listo));
               chk("ocupado_with_listo", 32'(ocupado), 32'd0);
               chk("busy_cycles", 32'(run), 32'(e.busy));
               if (e.gap != 0) chk("listo_spacing", 32'(int'($time) - last_listo), 32'(e.gap));
            end
            last_listo = int'($time);
            run = 0;
         end else if (ocupado) begin
            run++;
         end else begin
            run = 0;
         end
      end
   end

   vec_t dir_v[8] = '{
      '{a:4'd13, b:4'd3,  q:4'd4,  r:4'd1, dz:1'b0},
      '{a:4'd15, b:4'd1,  q:4'd15, r:4'd0, dz:1'b0},
      '{a:4'd2,  b:4'd7,  q:4'd0,  r:4'd2, dz:1'b0},
      '{a:4'd0,  b:4'd5,  q:4'd0,  r:4'd0, dz:1'b0},
      '{a:4'd15, b:4'd15, q:4'd1,  r:4'd0, dz:1'b0},
      '{a:4'd9,  b:4'd0,  q:4'hF,  r:4'd9, dz:1'b1},
      '{a:4'd8,  b:4'd2,  q:4'd4,  r:4'd0, dz:1'b0},
      '{a:4'd5,  b:4'd0,  q:4'hF,  r:4'd5, dz:1'b1}
   };

   vec_t held_v[3] = '{
      '{a:4'd13, b:4'd3, q:4'd4, r:4'd1, dz:1'b0},
      '{a:4'd8,  b:4'd2, q:4'd4, r:4'd0, dz:1'b0},
      '{a:4'd14, b:4'd3, q:4'd4, r:4'd2, dz:1'b0}
   };

   initial begin
      reset     = 1'b1;
      inicio    = 1'b0;
      Dividendo = '0;
      Divisor   = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_cociente", 32'(Cociente), 32'd0);
      chk("reset_residuo", 32'(Residuo), 32'd0);
      chk("reset_ocupado", 32'(ocupado), 32'd0);
      chk("reset_listo", 32'(listo), 32'd0);
      chk("reset_div_cero", 32'(div_cero), 32'd0);
      reset = 1'b0;

      foreach (dir_v[i]) run_op(dir_v[i].a, dir_v[i].b, dir_v[i].q, dir_v[i].r, dir_v[i].dz);

      // Abort 14/3 with reset on its second iteration edge; last result was 5/0.
      @(negedge clk);
      Dividendo = 4'd14;
      Divisor   = 4'd3;
      inicio    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      inicio = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("abort_cociente", 32'(Cociente), 32'd0);
      chk("abort_residuo", 32'(Residuo), 32'd0);
      chk("abort_ocupado", 32'(ocupado), 32'd0);
      chk("abort_listo", 32'(listo), 32'd0);
      chk("abort_div_cero", 32'(div_cero), 32'd0);
      reset = 1'b0;
      repeat (N + 2) @(negedge clk);
      run_op(4'd14, 4'd3, 4'd4, 4'd2, 1'b0);

      // inicio held high; operands churn while busy, the next pair is
      // presented exactly at the first edge back in REPOSO.
      foreach (held_v[i]) begin
         if (i > 0) begin
            for (int k = 0; k <= N; k++) begin
               @(negedge clk);
               Dividendo = 4'(k * 5 + 1);
               Divisor   = 4'(k + 1);
            end
         end
         @(negedge clk);
         Dividendo = held_v[i].a;
         Divisor   = held_v[i].b;
         inicio    = 1'b1;
         @(posedge clk);
         push_exp(held_v[i].q, held_v[i].r, 1'b0, int'($time), (i > 0) ? (N + 2) * PER : 0);
      end
      @(negedge clk);
      inicio = 1'b0;
      repeat (N + 1) @(negedge clk);

      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            if (b == 0) run_op(4'(a), 4'(b), 4'hF, 4'(a), 1'b1);
            else        run_op(4'(a), 4'(b), 4'(a / b), 4'(a % b), 1'b0);
         end
      end

      repeat (10) @(negedge clk);
      chk("pending_results", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
